// File: rtl/padder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   pg_t     : propagate/generate vector pair, sized for the widest legal operand
//   clog2    : ceiling log2 used to count prefix levels
//   calc_lat : pipeline depth in cycles for a given width and levels-per-stage
package padder_pkg;

    localparam int MAX_N = 64;

    typedef struct packed {
        logic [MAX_N-1:0] p;
        logic [MAX_N-1:0] g;
    } pg_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // One cycle minimum: the output register always exists even when all
    // prefix levels fit in a single stage.
    function automatic int calc_lat(input int n, input int lvl_per_stg);
        int levels;
        int lat;
        levels = clog2(n);
        lat    = (levels + lvl_per_stg - 1) / lvl_per_stg;
        if (lat < 1) begin
            lat = 1;
        end
        return lat;
    endfunction

endpackage

// File: rtl/padder_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each position with the one DIST below.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides where registers go.
//   pg_i : propagate/generate vectors into the level (bits >= N pass through)
//   pg_o : propagate/generate vectors out of the level
module padder_prefix_level
    import padder_pkg::*;
#(
    parameter int N    = 16,
    parameter int DIST = 1
) (
    input  pg_t pg_i,
    output pg_t pg_o
);

    always_comb begin
        // Positions below DIST already hold their full group and pass unchanged.
        pg_o = pg_i;
        for (int i = DIST; i < N; i++) begin
            pg_o.g[i] = pg_i.g[i] | (pg_i.p[i] & pg_i.g[i-DIST]);
            pg_o.p[i] = pg_i.p[i] & pg_i.p[i-DIST];
        end
    end

endmodule

// File: rtl/padder_pipe.sv
// Pipelined parallel-prefix adder/subtractor with carry in/out, overflow and zero flags.
// Latency: LAT = ceil(clog2(N)/LVL_PER_STG) (min 1) cycles from accept to out_valid; one result per cycle.
// Backpressure: single global advance; every stage holds while out_valid && !out_ready, in_ready follows it.
//   in  : clk, rst (sync, active high), in_valid, A, B, Cin, sub, in_tag, out_ready
//   out : in_ready, out_valid, S, Cout, Ovf, Zero, out_tag
module padder_pipe
    import padder_pkg::*;
#(
    parameter int N           = 16,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic             Cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG2N  = clog2(N);
    localparam int LAT    = calc_lat(N, LVL_PER_STG);
    localparam int NREG   = LAT - 1;                 // registers before the output stage
    localparam int NREG_D = (NREG > 0) ? NREG : 1;

    logic adv;
    logic out_valid_q;
    logic [N-1:0] s_q;
    logic cout_q, ovf_q, zero_q;
    logic [TAG_W-1:0] otag_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;
    assign out_tag   = otag_q;

    // Preprocess; Cin is folded into G[0] so no extra prefix position is needed.
    pg_t pre_pg;
    logic [N-1:0] pre_x;
    logic [N-1:0] bx;

    always_comb begin
        bx                = sub ? ~B : B;
        pre_pg            = '0;
        pre_pg.p[N-1:0]   = A | bx;
        pre_pg.g[N-1:0]   = A & bx;
        pre_pg.g[0]       = (A[0] & bx[0]) | ((A[0] | bx[0]) & Cin);
        pre_x             = A ^ bx;
    end

    // Intermediate stage registers; X, Cin and tag ride with their P/G.
    pg_t              pg_q      [NREG_D];
    logic [N-1:0]     x_q       [NREG_D];
    logic             cin_q     [NREG_D];
    logic [TAG_W-1:0] stg_tag_q [NREG_D];
    logic             vld_q     [NREG_D];

    pg_t lvl_in  [LOG2N];
    pg_t lvl_out [LOG2N];

    // A register sits after level k-1 whenever k is a multiple of LVL_PER_STG.
    for (genvar k = 0; k < LOG2N; k++) begin : g_lvl
        if (k == 0) begin : g_first
            assign lvl_in[k] = pre_pg;
        end else if ((k % LVL_PER_STG) == 0) begin : g_staged
            assign lvl_in[k] = pg_q[(k / LVL_PER_STG) - 1];
        end else begin : g_chained
            assign lvl_in[k] = lvl_out[k-1];
        end

        padder_prefix_level #(
            .N    (N),
            .DIST (1 << k)
        ) u_level (
            .pg_i (lvl_in[k]),
            .pg_o (lvl_out[k])
        );
    end

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        logic             vld_d;
        logic             cin_d;
        logic [N-1:0]     x_d;
        logic [TAG_W-1:0] tag_d;

        if (r == 0) begin : g_src_in
            assign vld_d = in_valid;
            assign cin_d = Cin;
            assign x_d   = pre_x;
            assign tag_d = in_tag;
        end else begin : g_src_stg
            assign vld_d = vld_q[r-1];
            assign cin_d = cin_q[r-1];
            assign x_d   = x_q[r-1];
            assign tag_d = stg_tag_q[r-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[r] <= 1'b0;
            end else if (adv) begin
                vld_q[r] <= vld_d;
                // Payload only moves with a valid op; bubbles leave it untouched.
                if (vld_d) begin
                    pg_q[r]      <= lvl_out[((r + 1) * LVL_PER_STG) - 1];
                    x_q[r]       <= x_d;
                    cin_q[r]     <= cin_d;
                    stg_tag_q[r] <= tag_d;
                end
            end
        end
    end

    // Final stage: remaining levels, then sum and flags into the output register.
    logic             fin_vld;
    logic             fin_cin;
    logic [N-1:0]     fin_x;
    logic [TAG_W-1:0] fin_tag;
    logic [N-1:0]     fin_g;
    logic [N-1:0]     carry;
    logic [N-1:0]     sum_d;
    logic             cout_d, ovf_d, zero_d;

    if (NREG > 0) begin : g_fin_stg
        assign fin_vld = vld_q[NREG-1];
        assign fin_cin = cin_q[NREG-1];
        assign fin_x   = x_q[NREG-1];
        assign fin_tag = stg_tag_q[NREG-1];
    end else begin : g_fin_in
        assign fin_vld = in_valid;
        assign fin_cin = Cin;
        assign fin_x   = pre_x;
        assign fin_tag = in_tag;
    end

    // After the last level G[i] is the group generate of bits i..0, i.e. carry into i+1.
    assign fin_g  = lvl_out[LOG2N-1].g[N-1:0];
    assign carry  = {fin_g[N-2:0], fin_cin};
    assign sum_d  = fin_x ^ carry;
    assign cout_d = fin_g[N-1];
    assign ovf_d  = carry[N-1] ^ fin_g[N-1];
    assign zero_d = (sum_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            otag_q      <= '0;
        end else if (adv) begin
            out_valid_q <= fin_vld;
            if (fin_vld) begin
                s_q    <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
                otag_q <= fin_tag;
            end
        end
    end

endmodule

// File: tb/tb_padder_pipe.sv
// Directed and random checks of padder_pipe at N=16, LVL_PER_STG=2 (two-cycle latency).
// Latency: n/a (bench).
// Backpressure: exercised by stalling out_ready mid-stream.
module tb_padder_pipe;

    localparam int N   = 16;
    localparam int LVL = 2;
    localparam int TW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A, B;
    logic          Cin, sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  S;
    logic          Cout, Ovf, Zero;
    logic [TW-1:0] out_tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    padder_pipe #(
        .N           (N),
        .LVL_PER_STG (LVL),
        .TAG_W       (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .Zero      (Zero),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    // Send one op into an empty pipe and wait (bounded) for its result.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input logic [3:0] tg,
                         output logic [15:0] s, output logic co, output logic ov,
                         output logic z, output logic [3:0] ot, output int lat);
        @(negedge clk);
        A = a; B = b; Cin = ci; sub = sb; in_tag = tg;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = -1;
        s = '0; co = 1'b0; ov = 1'b0; z = 1'b0; ot = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                s = S; co = Cout; ov = Ovf; z = Zero; ot = out_tag;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        A = 16'hABCD; B = 16'h1234; Cin = 1'b1; sub = 1'b0; in_tag = 4'h5;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || S !== 16'h0 || Cout !== 1'b0 || Ovf !== 1'b0 ||
            Zero !== 1'b0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b S=%h C=%b O=%b Z=%b tag=%h, need all zero",
                     out_valid, S, Cout, Ovf, Zero, out_tag);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b, need 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_arith();
        vec_t vecs [10];
        logic [15:0] s;
        logic co, ov, z;
        logic [3:0] ot;
        int lat;
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{16'h4000, 16'h4000, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, 4'(i), s, co, ov, z, ot, lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d cycles, need %0d", i, lat, LAT);
            end
            checks++;
            if (s !== vecs[i].s || co !== vecs[i].co || ov !== vecs[i].ov || z !== vecs[i].z) begin
                errors++;
                $display("FAIL arith_result[%0d]: got S=%h C=%b O=%b Z=%b, need S=%h C=%b O=%b Z=%b",
                         i, s, co, ov, z, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z);
            end
            checks++;
            if (ot !== 4'(i)) begin
                errors++;
                $display("FAIL arith_tag[%0d]: got %h, need %h", i, ot, 4'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q_s [$];
        logic [3:0]  q_t [$];
        int sent = 0;
        int recvd = 0;
        int first_c = -1;
        int last_c = -1;
        logic [15:0] a, b;
        for (int c = 0; c < 40 && recvd < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid === 1'b1) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                checks++;
                if (q_s.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got unexpected result S=%h tag=%h, need none", S, out_tag);
                end else if (S !== q_s[0] || out_tag !== q_t[0]) begin
                    errors++;
                    $display("FAIL b2b_data: got S=%h tag=%h, need S=%h tag=%h", S, out_tag, q_s[0], q_t[0]);
                end
                if (q_s.size() != 0) begin
                    void'(q_s.pop_front());
                    void'(q_t.pop_front());
                end
                recvd++;
            end
            if (sent < 10) begin
                a = 16'($urandom);
                b = 16'($urandom);
                A = a; B = b; Cin = 1'b0; sub = 1'b0; in_tag = 4'(sent);
                in_valid = 1'b1;
                q_s.push_back(a + b);
                q_t.push_back(4'(sent));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (recvd != 10 || first_c != LAT || last_c - first_c != 9) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d results in cycles %0d..%0d, need 10 in cycles %0d..%0d",
                     recvd, first_c, last_c, LAT, LAT + 9);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] q_s [$];
        logic [3:0]  q_t [$];
        int sent = 0;
        int recvd = 0;
        int stalls = 0;
        logic rdy;
        logic prev_stall = 1'b0;
        logic [15:0] prev_s = '0;
        logic [3:0]  prev_t = '0;
        for (int c = 0; c < 60 && recvd < 8; c++) begin
            @(negedge clk);
            rdy = !(c >= 4 && c <= 6);
            out_ready = rdy;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || S !== prev_s || out_tag !== prev_t) begin
                    errors++;
                    $display("FAIL bp_stable: got vld=%b S=%h tag=%h, need vld=1 S=%h tag=%h",
                             out_valid, S, out_tag, prev_s, prev_t);
                end
            end
            if (sent < 8) begin
                A = 16'h1111 * 16'(sent); B = 16'h0101; Cin = 1'b0; sub = 1'b0;
                in_tag = 4'(sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== (!out_valid || rdy)) begin
                errors++;
                $display("FAIL bp_in_ready: cycle %0d got %b, need %b", c, in_ready, (!out_valid || rdy));
            end
            if (out_valid === 1'b1 && !rdy) stalls++;
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (q_s.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got S=%h tag=%h, need no result", S, out_tag);
                end else if (S !== q_s[0] || out_tag !== q_t[0]) begin
                    errors++;
                    $display("FAIL bp_order: got S=%h tag=%h, need S=%h tag=%h", S, out_tag, q_s[0], q_t[0]);
                end
                if (q_s.size() != 0) begin
                    void'(q_s.pop_front());
                    void'(q_t.pop_front());
                end
                recvd++;
            end
            prev_stall = (out_valid === 1'b1) && !rdy;
            prev_s = S;
            prev_t = out_tag;
            if (in_valid && in_ready === 1'b1) begin
                q_s.push_back(A + B);
                q_t.push_back(in_tag);
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (recvd != 8 || stalls != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d results with %0d stalled cycles, need 8 and 3", recvd, stalls);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_dup: got out_valid=%b tag=%h after drain, need 0", out_valid, out_tag);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] s;
        logic co, ov, z;
        logic [3:0] ot;
        int lat;
        int seen = 0;
        @(negedge clk);
        out_ready = 1'b0;
        A = 16'h0001; B = 16'h0001; Cin = 1'b0; sub = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
        @(negedge clk);
        A = 16'h0002; in_tag = 4'hB;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'hA) begin
            errors++;
            $display("FAIL rstmid_inflight: got vld=%b tag=%h, need 1 and a", out_valid, out_tag);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || S !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got vld=%b S=%h, need 0 and 0000", out_valid, S);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_flushed: got %0d valid cycles after reset, need 0", seen);
        end
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 4'h3, s, co, ov, z, ot, lat);
        checks++;
        if (lat !== LAT || s !== 16'h1000 || ot !== 4'h3) begin
            errors++;
            $display("FAIL rstmid_after: got lat=%0d S=%h tag=%h, need lat=%0d S=1000 tag=3", lat, s, ot, LAT);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, bx, s;
        logic ci, sb, co, ov, z;
        logic [3:0] ot;
        logic [16:0] full;
        logic exp_ov;
        int lat;
        for (int i = 0; i < 150; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            sb = 1'($urandom);
            bx = sb ? ~b : b;
            full   = {1'b0, a} + {1'b0, bx} + {16'h0, ci};
            exp_ov = (a[15] == bx[15]) && (full[15] != a[15]);
            do_op(a, b, ci, sb, 4'(i), s, co, ov, z, ot, lat);
            checks++;
            if (lat !== LAT || s !== full[15:0] || co !== full[16] || ov !== exp_ov ||
                z !== (full[15:0] == 16'h0) || ot !== 4'(i)) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h ci=%b sub=%b: got lat=%0d S=%h C=%b O=%b Z=%b, need lat=%0d S=%h C=%b O=%b Z=%b",
                         i, a, b, ci, sb, lat, s, co, ov, z, LAT, full[15:0], full[16], exp_ov,
                         (full[15:0] == 16'h0));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
